// File: rtl/func_sweep_driver.sv
// rtl/func_sweep_driver.sv - exhaustive 4-input dual-rail vector sweeper and truth-table capture
//
// Purpose:
//   On an accepted start, drives all 16 vectors {a,b,c,d} = 0..15 onto
//   registered true/complement rails. Each vector is held for SETTLE_CYCLES+1
//   cycles. func_out is sampled on the last edge of each hold window into
//   truth_table[vector].
//
// Optional feature macro: FUNC_SWEEP_CHECK_EN
//   When defined, every sample is compared against golden[vector]. The first
//   failing vector is latched into mismatch/fail_idx.
//
// Parameters:
//   SETTLE_CYCLES   extra hold cycles per vector, 0..15
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           sweep request, only honoured while idle
//   func_out        output of the cell under stimulus
//   a,b,c,d         true rails of the current vector (a = MSB)
//   not_a..not_d    complement rails
//   busy            high for the whole sweep
//   done            one-cycle pulse after the final sample
//   truth_table     bit k = func_out sampled for vector k
//   golden          expected truth table (FUNC_SWEEP_CHECK_EN only)
//   mismatch        a sample differed from golden (FUNC_SWEEP_CHECK_EN only)
//   fail_idx        first differing vector (FUNC_SWEEP_CHECK_EN only)

module func_sweep_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        func_out,
`ifdef FUNC_SWEEP_CHECK_EN
    input  logic [15:0] golden,
    output logic        mismatch,
    output logic [3:0]  fail_idx,
`endif
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        not_a,
    output logic        not_b,
    output logic        not_c,
    output logic        not_d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LAST = SETTLE_CYCLES[3:0];
    localparam logic [3:0] VEC_LAST    = 4'd15;

    state_e      state_q, state_d;
    logic [3:0]  vec_q,   vec_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] tt_q,    tt_d;

`ifdef FUNC_SWEEP_CHECK_EN
    logic        mis_q,   mis_d;
    logic [3:0]  fidx_q,  fidx_d;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            tt_q    <= 16'h0000;
`ifdef FUNC_SWEEP_CHECK_EN
            mis_q   <= 1'b0;
            fidx_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
`ifdef FUNC_SWEEP_CHECK_EN
            mis_q   <= mis_d;
            fidx_q  <= fidx_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
`ifdef FUNC_SWEEP_CHECK_EN
        mis_d   = mis_q;
        fidx_d  = fidx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                vec_d = 4'd0;
                if (start) begin
                    tt_d    = 16'h0000;
                    cnt_d   = 4'd0;
                    state_d = ST_HOLD;
`ifdef FUNC_SWEEP_CHECK_EN
                    mis_d   = 1'b0;
                    fidx_d  = 4'd0;
`endif
                end
            end

            ST_HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    // Last edge of this vector's window: capture raw, so a
                    // floating or contended cell output is preserved as-is.
                    tt_d[vec_q] = func_out;
`ifdef FUNC_SWEEP_CHECK_EN
                    // Case inequality so an X/Z sample is treated as a fail.
                    if (!mis_q && (func_out !== golden[vec_q])) begin
                        mis_d  = 1'b1;
                        fidx_d = vec_q;
                    end
`endif
                    cnt_d = 4'd0;
                    // Vector stops at 15; it never wraps inside a sweep.
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_DONE: begin
                // Start is not looked at here, so requests are not queued.
                vec_d   = 4'd0;
                state_d = ST_IDLE;
            end

            default: begin
                vec_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: both rails come from the single vector register, so they
    // are complementary in every cycle, including while in reset.
    // ------------------------------------------------------------------
    assign a     = vec_q[3];
    assign b     = vec_q[2];
    assign c     = vec_q[1];
    assign d     = vec_q[0];
    assign not_a = ~vec_q[3];
    assign not_b = ~vec_q[2];
    assign not_c = ~vec_q[1];
    assign not_d = ~vec_q[0];

    assign busy        = (state_q == ST_HOLD);
    assign done        = (state_q == ST_DONE);
    assign truth_table = tt_q;

`ifdef FUNC_SWEEP_CHECK_EN
    assign mismatch = mis_q;
    assign fail_idx = fidx_q;
`endif

endmodule

// File: tb/tb_func_sweep_driver.sv
// tb/tb_func_sweep_driver.sv - randomized self-checking bench for func_sweep_driver

module tb_func_sweep_driver;

    localparam int S1 = 1;
    localparam int S0 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with default settle (1)
    logic        rst1, start1, fo1;
    logic        a1, b1, c1, d1, na1, nb1, nc1, nd1, busy1, done1;
    logic [15:0] tt1;
    logic [15:0] cell_fn;
    logic [15:0] fmask;
    logic [3:0]  vec1;
`ifdef FUNC_SWEEP_CHECK_EN
    logic [15:0] golden1;
    logic        mis1;
    logic [3:0]  fidx1;
`endif

    // Instance with zero settle, output tied to d
    logic        rst0, start0, fo0;
    logic        a0, b0, c0, d0, na0, nb0, nc0, nd0, busy0, done0;
    logic [15:0] tt0;

    assign vec1 = {a1, b1, c1, d1};
    // Behavioural function cell, with per-vector stuck-at-0 forcing.
    assign fo1  = fmask[vec1] ? 1'b0 : cell_fn[vec1];
    assign fo0  = d0;

    func_sweep_driver #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .func_out(fo1),
`ifdef FUNC_SWEEP_CHECK_EN
        .golden(golden1), .mismatch(mis1), .fail_idx(fidx1),
`endif
        .a(a1), .b(b1), .c(c1), .d(d1),
        .not_a(na1), .not_b(nb1), .not_c(nc1), .not_d(nd1),
        .busy(busy1), .done(done1), .truth_table(tt1)
    );

    func_sweep_driver #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .func_out(fo0),
`ifdef FUNC_SWEEP_CHECK_EN
        .golden(16'hAAAA), .mismatch(), .fail_idx(),
`endif
        .a(a0), .b(b0), .c(c0), .d(d0),
        .not_a(na0), .not_b(nb0), .not_c(nc0), .not_d(nd0),
        .busy(busy0), .done(done0), .truth_table(tt0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rails must be complementary on every cycle for both instances.
    always @(negedge clk) begin
        n_checks++;
        assert ({na1, nb1, nc1, nd1} === ~{a1, b1, c1, d1} &&
                {na0, nb0, nc0, nd0} === ~{a0, b0, c0, d0}) else begin
            n_fail++;
            $error("FAIL rails_compl: observed %b/%b %b/%b", {a1, b1, c1, d1}, {na1, nb1, nc1, nd1},
                   {a0, b0, c0, d0}, {na0, nb0, nc0, nd0});
        end
    end

    // Walk a sweep of dut1 from its first busy cycle; the vector expected
    // in busy cycle k is k/(S1+1).
    task automatic run1(output int k, output int bad);
        k   = 0;
        bad = 0;
        while (busy1 === 1'b1 && k < 400) begin
            if (vec1 !== 4'(k / (S1 + 1))) bad++;
            k++;
            tick();
        end
    endtask

    task automatic sweep1(input string tag, input logic [15:0] exp_tt);
        int k, bad;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk({tag, "_busy_first"}, 32'(busy1), 32'd1);
        run1(k, bad);
        chk({tag, "_busy_cycles"}, 32'(k), 32'(16 * (S1 + 1)));
        chk({tag, "_vec_seq_errs"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(done1), 32'd1);
        chk({tag, "_tt"}, 32'(tt1), 32'(exp_tt));
    endtask

    function automatic int first_diff(input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < 16; i++) if (x[i] != y[i]) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, bad, fd;
        logic [15:0] fn_r, gold_r;

        rst1 = 1'b1; start1 = 1'b0; cell_fn = 16'h0000; fmask = 16'h0000;
        rst0 = 1'b1; start0 = 1'b0;
`ifdef FUNC_SWEEP_CHECK_EN
        golden1 = 16'h0000;
`endif
        tick(); tick();
        rst1 = 1'b0; rst0 = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_rails", 32'({a1, b1, c1, d1, na1, nb1, nc1, nd1}), 32'h0F);
        chk("rst_busy_done", 32'({busy1, done1}), 32'd0);
        chk("rst_tt", 32'(tt1), 32'h0);
        chk("rst0_rails", 32'({a0, b0, c0, d0, na0, nb0, nc0, nd0}), 32'h0F);
        chk("rst0_tt", 32'(tt0), 32'h0);
`ifdef FUNC_SWEEP_CHECK_EN
        chk("rst_mis", 32'({mis1, fidx1}), 32'h0);
`endif

        // Reference cell function
        cell_fn = 16'hDC51;
        sweep1("cell", 16'hDC51);
        tick();
        chk("cell_after_done", 32'({busy1, done1}), 32'd0);
        chk("cell_tt_hold", 32'(tt1), 32'hDC51);
        tick();
        chk("cell_tt_hold2", 32'(tt1), 32'hDC51);

        // Zero settle, func_out = d
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0; bad = 0;
        while (busy0 === 1'b1 && k < 400) begin
            if ({a0, b0, c0, d0} !== 4'(k / (S0 + 1))) bad++;
            k++;
            tick();
        end
        chk("s0_busy_cycles", 32'(k), 32'd16);
        chk("s0_vec_seq_errs", 32'(bad), 32'd0);
        chk("s0_done", 32'(done0), 32'd1);
        chk("s0_tt", 32'(tt0), 32'hAAAA);

        // Start held high: two sweeps separated by one idle cycle
        cell_fn = 16'h1234;
        start1 = 1'b1;
        tick();
        chk("held_busy1", 32'(busy1), 32'd1);
        run1(k, bad);
        chk("held_cycles1", 32'(k), 32'd32);
        chk("held_seq1", 32'(bad), 32'd0);
        chk("held_done1", 32'(done1), 32'd1);
        chk("held_tt1", 32'(tt1), 32'h1234);
        tick();
        chk("held_idle_gap", 32'({busy1, done1}), 32'd0);
        tick();
        chk("held_busy2", 32'(busy1), 32'd1);
        chk("held_vec2", 32'(vec1), 32'd0);
        run1(k, bad);
        chk("held_cycles2", 32'(k), 32'd32);
        chk("held_seq2", 32'(bad), 32'd0);
        chk("held_done2", 32'(done1), 32'd1);
        start1 = 1'b0;
        tick();
        chk("held_release_idle1", 32'(busy1), 32'd0);
        tick();
        chk("held_release_idle2", 32'(busy1), 32'd0);

        // Reset in the middle of vector 7's hold window
        cell_fn = 16'hFFFF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (15) tick();
        chk("midrst_vec7", 32'(vec1), 32'd7);
        rst1 = 1'b1;
        tick();
        chk("midrst_rails", 32'({a1, b1, c1, d1, na1, nb1, nc1, nd1}), 32'h0F);
        chk("midrst_busy_done", 32'({busy1, done1}), 32'd0);
        chk("midrst_tt", 32'(tt1), 32'h0);
        rst1 = 1'b0;
        tick();
        chk("midrst_no_done", 32'({busy1, done1}), 32'd0);
        cell_fn = 16'h5A3C;
        sweep1("postrst", 16'h5A3C);
        tick();

        // Random functions
        for (int r = 0; r < 4; r++) begin
            fn_r = 16'($urandom);
            cell_fn = fn_r;
`ifdef FUNC_SWEEP_CHECK_EN
            golden1 = fn_r;
`endif
            sweep1("rand", fn_r);
            tick();
        end

`ifdef FUNC_SWEEP_CHECK_EN
        // Golden compare with stuck-at-0 at vectors 10 and 14
        cell_fn = 16'hDC51;
        golden1 = 16'hDC51;
        fmask   = 16'h4400;
        sweep1("chk_forced", 16'hDC51 & ~16'h4400);
        chk("chk_forced_mis", 32'(mis1), 32'd1);
        chk("chk_forced_idx", 32'(fidx1), 32'd10);
        tick();
        fmask = 16'h0000;
        sweep1("chk_clean", 16'hDC51);
        chk("chk_clean_mis", 32'({mis1, fidx1}), 32'h0);
        tick();
        for (int r = 0; r < 4; r++) begin
            fn_r   = 16'($urandom);
            gold_r = fn_r ^ (16'(1) << $urandom_range(15, 0)) ^ ((r[0]) ? 16'($urandom) : 16'h0);
            cell_fn = fn_r;
            golden1 = gold_r;
            fd = first_diff(fn_r, gold_r);
            sweep1("chk_rand", fn_r);
            chk("chk_rand_mis", 32'(mis1), 32'(fd >= 0));
            chk("chk_rand_idx", 32'(fidx1), (fd >= 0) ? 32'(fd) : 32'd0);
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/func_sweep_driver.md
# func_sweep_driver

Upstream stimulus stage for the switch-level 4-input CMOS function cell. On a `start` request it sweeps all 16 input vectors {a,b,c,d} and drives them as registered dual rails, true and complement, into the cell. After a programmable settle time it samples the cell's `out` and assembles a 16-bit captured truth table. It is used both as the bring-up driver for the function cell and as the exhaustive self-check harness for it.

## Interface
- `SETTLE_CYCLES`, default 1: extra cycles each vector is held before `func_out` is sampled. Legal range 0..15.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: sweep request. Sampled only in IDLE.
- `func_out` input 1: `out` of the function cell.
- `a`, `b`, `c`, `d` output 1 each: true rails of the current vector. `a` = vector bit 3 (MSB), `d` = bit 0.
- `not_a`, `not_b`, `not_c`, `not_d` output 1 each: complement rails.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: one-cycle pulse when a sweep completes.
- `truth_table` output 16: bit k = `func_out` sampled for vector k.
- With `FUNC_SWEEP_CHECK_EN` only: `golden` input 16, `mismatch` output 1, `fail_idx` output 4.

## Operation
- FSM states: IDLE, HOLD, DONE.
- IDLE: vector = 0. If `start`=1: clear `truth_table` to 0, set the hold counter to 0, set `busy`=1, go to HOLD.
- HOLD: the vector is held while the hold counter counts 0..`SETTLE_CYCLES`. On the edge where counter = `SETTLE_CYCLES`:
  - write `func_out` into `truth_table[vector]`.
  - if vector = 15, go to DONE.
  - otherwise increment the vector and reset the counter.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE. Vector returns to 0 on entry to IDLE.
- Dual rails: both rails are driven from the same vector register, so `not_x` = ~`x` in every cycle, including reset. No cycle ever drives both rails equal.
- `start` while in HOLD or DONE is ignored and is not queued.
- `truth_table` holds its value from DONE until the next accepted `start`.
- `func_out` X/Z (contention or float in the cell) is stored raw into `truth_table`.
- Reset values: `a`..`d`=0, `not_a`..`not_d`=1, `busy`=0, `done`=0, `truth_table`=0, `mismatch`=0, `fail_idx`=0, state IDLE.
- Reset mid-sweep aborts the sweep. All reset values appear on the edge where `rst`=1, and no `done` pulse is produced.
- Vector counter is 4 bits. It is never allowed to wrap past 15 inside a sweep.

## Timing
- `start` accepted at edge E: vector 0 is on the rails and `busy`=1 starting in the cycle after E.
- Each vector is held for `SETTLE_CYCLES`+1 cycles. The sample is taken on the last edge of its window.
- Full sweep: 16×(`SETTLE_CYCLES`+1) cycles of `busy`. `done` follows the final sample by one edge. The default gives 32 busy cycles.
- `truth_table[15]` is valid in the same cycle that `done`=1.
- Back-to-back sweeps: the earliest next `start` is accepted on the edge after `done`. This leaves 1 idle cycle minimum.

## Configuration
- `FUNC_SWEEP_CHECK_EN` defined: golden compare is compiled in.
  - Each sample is compared against `golden[vector]` using case inequality, so X/Z counts as a fail.
  - The first failing vector latches `mismatch`=1 and `fail_idx` = that vector.
  - Later fails do not overwrite `fail_idx`.
  - Both are cleared on an accepted `start` and on reset.
  - `golden` is sampled per vector and must be stable while `busy`=1.
- `FUNC_SWEEP_CHECK_EN` undefined: the `golden`, `mismatch` and `fail_idx` ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: rails read a..d=0000, not_*=1111; `busy`=0, `done`=0, `truth_table`=0x0000.
- Real function cell attached, `SETTLE_CYCLES`=1, `start` pulse: `busy` high for 32 cycles, then one `done` cycle; `truth_table`=0xDC51.
- `SETTLE_CYCLES`=0, `func_out` tied to `d`: `busy` for 16 cycles; `truth_table`=0xAAAA. Every cycle checks rails are complementary.
- `start` held high continuously: sweeps are separated by exactly one IDLE cycle. A `start` during HOLD does not restart or shorten the sweep.
- `rst` asserted at vector 7 mid-hold: next cycle shows all reset values and no `done`. A fresh sweep then completes normally.
- Check build, golden=0xDC51 with `func_out` forced to 0 at vectors 10 and 14: `mismatch`=1, `fail_idx`=10 at `done`. With no forcing: `mismatch`=0.
